sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Parametrised bridge converting NCH independent SRAM-like request channels (req/addr_ok/data_ok) into one AXI3/AXI4 master port for the CPU top level. It generalises the fixed two-channel instruction/data bridge: the channel count and the per-channel outstanding-read depth are parameters. Arbitration is round-robin, and read/write ordering is enforced per channel. It sits between the core and the AXI crossbar/memory model.

## Interface
- NCH, 2, number of SRAM-like channels (1..16); channel index is the AXI ID
- MAX_OUT, 2, max outstanding reads per channel (1..15)
- clk  in  1  clock, all logic rising-edge
- resetn  in  1  reset; asynchronous, active-low
- sram_req  in  NCH  per-channel request
- sram_wr  in  NCH  1 = write
- sram_size  in  2*NCH  0/1/2 = byte/half/word
- sram_wstrb  in  4*NCH  write byte strobes
- sram_addr  in  32*NCH  byte address
- sram_wdata  in  32*NCH  write data
- sram_addr_ok  out  NCH  request accepted this cycle
- sram_data_ok  out  NCH  read data valid / write completed
- sram_rdata  out  32*NCH  read data, valid with data_ok
- arid/araddr/arsize/arvalid  out  4/32/3/1  AR channel
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel
- rready  out  1  constant 1
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AW channel
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  W channel; wlast constant 1
- wready  in  1
- bid/bresp/bvalid  in  4/2/1  B channel
- bready  out  1  constant 1
- arlen/awlen 0, arburst/awburst 2'b01, arlock/awlock 0, arcache/awcache 0, arprot/awprot 0  out  constants

## Operation
- Round-robin pointer rr (0..NCH-1): at most one channel granted per cycle, first eligible channel at or after rr; on grant rr <= granted+1 (mod NCH).
- Read eligible for channel i: req&~wr, AR slot free (arvalid=0, or arvalid&arready this cycle), rd_cnt[i] < MAX_OUT, no RAW block.
- Write eligible: req&wr, write FSM in W_IDLE, rd_cnt[i] == 0 (preserves per-channel data_ok order).
- sram_addr_ok[i] is combinational, asserted only for the granted channel; an AR or AW/W beat is registered the same edge.
- AR register: arid=i, araddr=addr, arsize={1'b0,size}; held stable until arready.
- rd_cnt[i]: +1 on read grant, -1 on rvalid&rlast&rid==i; both in one cycle -> unchanged.
- R routing: sram_data_ok[i] = rvalid & rid==i; sram_rdata[i] = rdata (combinational pass-through).
- Write FSM: W_IDLE -> W_SEND on grant (awvalid=wvalid=1, wr_ch, wr_addr latched); awvalid and wvalid drop independently on their own handshakes; when both done -> W_WAITB; bvalid&bid==wr_ch -> sram_data_ok[wr_ch]=1, W_IDLE.
- RAW block: base behaviour blocks every read while FSM != W_IDLE.
- rresp/bresp ignored.

## Timing
- Reset (resetn=0, asynchronous): arvalid=awvalid=wvalid=0, all rd_cnt=0, rr=0, FSM=W_IDLE, all addr_ok/data_ok=0.
- Read: addr_ok cycle N -> arvalid from N+1; data_ok same cycle as rvalid.
- Write: addr_ok cycle N -> awvalid/wvalid from N+1; data_ok same cycle as bvalid; next write grantable the cycle after bvalid.
- AW and W may complete in either order or together; FSM reaches W_WAITB the cycle after the later one.
- Back-to-back reads: one AR per cycle when arready held high.

## Configuration
- SRAM_AXI_RAW_ADDR_CHECK_EN defined: a read is blocked only if FSM != W_IDLE and (araddr[31:2] == wr_addr[31:2] or requesting channel == wr_ch); other reads proceed during a write.
- Undefined: any pending write blocks all reads (described above).

## Test plan
- Reset mid-write (W_SEND, awvalid=1) -> awvalid/wvalid drop immediately; after release first read grant gives arid=0.
- NCH=2, both channels reading continuously, arready=1 -> grants alternate 0,1,0,1; each rd_cnt saturates at MAX_OUT=2 when R withheld.
- Channel 1 read 0x1000, rvalid rid=1 rdata=0xDEADBEEF -> sram_data_ok=2'b10, sram_rdata[63:32]=0xDEADBEEF.
- Write 0x2000 wstrb 4'b0011; wready 3 cycles before awready -> FSM waits for both, data_ok on bvalid only.
- Write 0x2000 pending, channel 0 reads 0x3000 -> blocked without macro; granted with macro; read 0x2004 blocked in both.
- Channel 0 read outstanding then channel 0 write -> write addr_ok withheld until read rlast returns.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: NCH SRAM-like request channels merged onto one AXI3/AXI4
// master port. Round-robin grant of at most one request per cycle. Each
// channel may have up to MAX_OUT reads in flight. A channel's write waits
// until all of that channel's reads have returned. Only one write is in
// flight at a time.
// Optional feature macro: SRAM_AXI_RAW_ADDR_CHECK_EN. When it is defined, a
// pending write blocks only reads that target the same word or come from the
// writing channel. When it is undefined, a pending write blocks every read.
module sram_axi_bridge #(
  parameter int NCH     = 2,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    sram_req,
  input  logic [NCH-1:0]    sram_wr,
  input  logic [2*NCH-1:0]  sram_size,
  input  logic [4*NCH-1:0]  sram_wstrb,
  input  logic [32*NCH-1:0] sram_addr,
  input  logic [32*NCH-1:0] sram_wdata,
  output logic [NCH-1:0]    sram_addr_ok,
  output logic [NCH-1:0]    sram_data_ok,
  output logic [32*NCH-1:0] sram_rdata,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_SEND  = 2'd1,
    W_WAITB = 2'd2
  } w_state_e;

  w_state_e        w_state_q;
  logic [CW-1:0]   rr_q;
  logic [3:0]      rd_cnt_q [NCH];

  logic            arvalid_q;
  logic [3:0]      arid_q;
  logic [31:0]     araddr_q;
  logic [2:0]      arsize_q;

  logic            awvalid_q;
  logic            wvalid_q;
  logic [CW-1:0]   wr_ch_q;
  logic [31:0]     wr_addr_q;
  logic [2:0]      awsize_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;

  logic [NCH-1:0]  rd_elig;
  logic [NCH-1:0]  wr_elig;
  logic [NCH-1:0]  raw_blk;
  logic [NCH-1:0]  rd_inc;
  logic [NCH-1:0]  rd_dec;
  logic            ar_free;
  logic            gnt_valid;
  logic            gnt_wr;
  logic [CW-1:0]   gnt_ch;
  logic            rd_gnt;
  logic            wr_gnt;
  logic            b_done;
  logic [31:0]     sel_addr;
  logic [1:0]      sel_size;
  logic [3:0]      sel_wstrb;
  logic [31:0]     sel_wdata;
  logic            unused_ok;

  assign ar_free = !arvalid_q || arready;
  assign rd_gnt  = gnt_valid && !gnt_wr;
  assign wr_gnt  = gnt_valid && gnt_wr;
  assign b_done  = (w_state_q == W_WAITB) && bvalid && (bid == 4'(wr_ch_q));

  // Per-channel eligibility, including the read-after-write block.
  always_comb begin
    rd_elig = '0;
    wr_elig = '0;
    raw_blk = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef SRAM_AXI_RAW_ADDR_CHECK_EN
      raw_blk[i] = (w_state_q != W_IDLE) &&
                   ((sram_addr[32*i+2 +: 30] == wr_addr_q[31:2]) || (wr_ch_q == CW'(i)));
`else
      raw_blk[i] = (w_state_q != W_IDLE);
`endif
      rd_elig[i] = sram_req[i] && !sram_wr[i] && ar_free &&
                   (rd_cnt_q[i] < 4'(MAX_OUT)) && !raw_blk[i];
      wr_elig[i] = sram_req[i] && sram_wr[i] && (w_state_q == W_IDLE) &&
                   (rd_cnt_q[i] == 4'd0);
    end
  end

  // Round-robin search: first eligible channel at or after rr_q.
  always_comb begin
    logic [CW:0] sum;
    gnt_valid = 1'b0;
    gnt_wr    = 1'b0;
    gnt_ch    = '0;
    sum       = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, rr_q} + (CW+1)'(k);
      if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
      for (int i = 0; i < NCH; i++) begin
        if (!gnt_valid && (sum[CW-1:0] == CW'(i)) && (rd_elig[i] || wr_elig[i])) begin
          gnt_valid = 1'b1;
          gnt_wr    = wr_elig[i];
          gnt_ch    = CW'(i);
        end
      end
    end
  end

  // Request fields of the granted channel.
  always_comb begin
    sel_addr  = '0;
    sel_size  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_ch == CW'(i)) begin
        sel_addr  = sram_addr[32*i +: 32];
        sel_size  = sram_size[2*i +: 2];
        sel_wstrb = sram_wstrb[4*i +: 4];
        sel_wdata = sram_wdata[32*i +: 32];
      end
    end
  end

  // Handshakes back to the channels; read data is broadcast, data_ok picks the owner.
  always_comb begin
    sram_addr_ok = '0;
    sram_data_ok = '0;
    rd_inc       = '0;
    rd_dec       = '0;
    for (int i = 0; i < NCH; i++) begin
      sram_addr_ok[i] = gnt_valid && (gnt_ch == CW'(i));
      sram_data_ok[i] = (rvalid && (rid == 4'(i))) || (b_done && (wr_ch_q == CW'(i)));
      rd_inc[i]       = rd_gnt && (gnt_ch == CW'(i));
      rd_dec[i]       = rvalid && rlast && (rid == 4'(i));
    end
  end

  assign sram_rdata = {NCH{rdata}};

  // Round-robin pointer advances past each granted channel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q <= '0;
    end else if (gnt_valid) begin
      rr_q <= (gnt_ch == CW'(NCH-1)) ? '0 : gnt_ch + 1'b1;
    end
  end

  // Outstanding read counters; a grant and a last beat in the same cycle cancel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) rd_cnt_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rd_inc[i] && !rd_dec[i])      rd_cnt_q[i] <= rd_cnt_q[i] + 4'd1;
        else if (rd_dec[i] && !rd_inc[i]) rd_cnt_q[i] <= rd_cnt_q[i] - 4'd1;
      end
    end
  end

  // AR register: loaded on a read grant, held until arready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
    end else if (rd_gnt) begin
      arvalid_q <= 1'b1;
      arid_q    <= 4'(gnt_ch);
      araddr_q  <= sel_addr;
      arsize_q  <= {1'b0, sel_size};
    end else if (arready) begin
      arvalid_q <= 1'b0;
    end
  end

  // Write FSM: AW and W complete independently, then wait for the matching B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_ch_q   <= '0;
      wr_addr_q <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wr_gnt) begin
            w_state_q <= W_SEND;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wr_ch_q   <= gnt_ch;
            wr_addr_q <= sel_addr;
            awsize_q  <= {1'b0, sel_size};
            wdata_q   <= sel_wdata;
            wstrb_q   <= sel_wstrb;
          end
        end
        W_SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) w_state_q <= W_WAITB;
        end
        W_WAITB: begin
          if (b_done) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign arvalid = arvalid_q;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  assign awvalid = awvalid_q;
  assign awid    = 4'(wr_ch_q);
  assign awaddr  = wr_addr_q;
  assign awsize  = awsize_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wvalid  = wvalid_q;
  assign wid     = 4'(wr_ch_q);
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

  // Response codes are not reported back to the channels.
  assign unused_ok = ^{rresp, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with NCH=2, MAX_OUT=2.
module tb_sram_axi_bridge;

`ifdef SRAM_AXI_RAW_ADDR_CHECK_EN
  localparam bit RAW_CHK = 1'b1;
`else
  localparam bit RAW_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [3:0]  sram_size;
  logic [7:0]  sram_wstrb;
  logic [63:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  arid, arcache, rid, awid, awcache, wid, wstrb, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int tests_run = 0;
  int failed    = 0;

  sram_axi_bridge #(.NCH(2), .MAX_OUT(2)) dut (
    .clk(clk), .resetn(resetn),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic idle();
    sram_req = '0; sram_wr = '0; sram_size = '0; sram_wstrb = '0;
    sram_addr = '0; sram_wdata = '0;
    rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rresp = '0;
    bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  task automatic rd_req(input int ch, input logic [31:0] addr);
    sram_req[ch] = 1'b1; sram_wr[ch] = 1'b0;
    sram_addr[32*ch +: 32] = addr; sram_size[2*ch +: 2] = 2'd2;
  endtask

  task automatic wr_req(input int ch, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] strb, input logic [31:0] data);
    sram_req[ch] = 1'b1; sram_wr[ch] = 1'b1;
    sram_addr[32*ch +: 32] = addr; sram_size[2*ch +: 2] = size;
    sram_wstrb[4*ch +: 4] = strb; sram_wdata[32*ch +: 32] = data;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data);
    rvalid = 1'b1; rid = id; rlast = 1'b1; rdata = data;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({arvalid, awvalid, wvalid, sram_addr_ok, sram_data_ok} !== 7'b0) begin
      failed++;
      $display("FAIL reset_valids: got %b expected 0", {arvalid, awvalid, wvalid, sram_addr_ok, sram_data_ok});
    end
    tests_run++;
    if ({rready, bready, wlast, arlen, arburst, awburst} !== {3'b111, 8'd0, 2'b01, 2'b01}) begin
      failed++;
      $display("FAIL reset_consts: got %h expected %h", {rready, bready, wlast, arlen, arburst, awburst},
               {3'b111, 8'd0, 2'b01, 2'b01});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_rr_saturate();
    logic [1:0] exp_ok [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [4:0] exp_ar [6] = '{5'h00, 5'h10, 5'h11, 5'h10, 5'h11, 5'h00};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle();
      rd_req(0, 32'h100); rd_req(1, 32'h200); arready = 1'b1;
      #1;
      tests_run++;
      if (sram_addr_ok !== exp_ok[c]) begin
        failed++;
        $display("FAIL rr_addr_ok[%0d]: got %b expected %b", c, sram_addr_ok, exp_ok[c]);
      end
      tests_run++;
      if ({arvalid, arvalid ? arid : 4'h0} !== exp_ar[c]) begin
        failed++;
        $display("FAIL rr_ar[%0d]: got %h expected %h", c, {arvalid, arvalid ? arid : 4'h0}, exp_ar[c]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      r_beat(4'(k % 2), 32'h1111_1111 * (k + 1));
      #1;
      tests_run++;
      if (sram_data_ok !== ((k % 2) ? 2'b10 : 2'b01) ||
          sram_rdata[32*(k%2) +: 32] !== 32'h1111_1111 * (k + 1)) begin
        failed++;
        $display("FAIL rr_drain[%0d]: data_ok %b rdata %h expected %b %h", k, sram_data_ok,
                 sram_rdata[32*(k%2) +: 32], ((k % 2) ? 2'b10 : 2'b01), 32'h1111_1111 * (k + 1));
      end
    end
  endtask

  task automatic test_read_route();
    @(negedge clk); idle(); rd_req(1, 32'h1000); arready = 1'b0;
    #1;
    tests_run++;
    if (sram_addr_ok !== 2'b10) begin
      failed++; $display("FAIL rd_addr_ok: got %b expected 10", sram_addr_ok);
    end
    @(negedge clk); idle(); #1;
    tests_run++;
    if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd1, 32'h1000, 3'd2}) begin
      failed++; $display("FAIL rd_ar: got %h expected %h", {arvalid, arid, araddr, arsize}, {1'b1, 4'd1, 32'h1000, 3'd2});
    end
    @(negedge clk); idle(); arready = 1'b1; #1;
    tests_run++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h1000}) begin
      failed++; $display("FAIL rd_ar_hold: got %h expected %h", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h1000});
    end
    @(negedge clk); idle(); r_beat(4'd1, 32'hDEAD_BEEF); #1;
    tests_run++;
    if ({arvalid, sram_data_ok, sram_rdata[63:32]} !== {1'b0, 2'b10, 32'hDEAD_BEEF}) begin
      failed++; $display("FAIL rd_route: got %h expected %h", {arvalid, sram_data_ok, sram_rdata[63:32]},
                         {1'b0, 2'b10, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_write_order();
    @(negedge clk); idle(); wr_req(0, 32'h2000, 2'd1, 4'b0011, 32'hA5A5_5A5A);
    awready = 1'b0; wready = 1'b0; #1;
    tests_run++;
    if (sram_addr_ok !== 2'b01) begin
      failed++; $display("FAIL wr_addr_ok: got %b expected 01", sram_addr_ok);
    end
    @(negedge clk); idle(); wready = 1'b1; #1;
    tests_run++;
    if ({awvalid, wvalid, awid, awaddr, awsize, wid, wstrb, wdata} !==
        {2'b11, 4'd0, 32'h2000, 3'd1, 4'd0, 4'b0011, 32'hA5A5_5A5A}) begin
      failed++; $display("FAIL wr_aw_w: got %h expected %h", {awvalid, wvalid, awid, awaddr, awsize, wid, wstrb, wdata},
                         {2'b11, 4'd0, 32'h2000, 3'd1, 4'd0, 4'b0011, 32'hA5A5_5A5A});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); wready = 1'b0; awready = (c == 2);
      wr_req(1, 32'h2100, 2'd2, 4'hF, 32'h0);
      #1;
      tests_run++;
      if ({awvalid, wvalid, sram_addr_ok, sram_data_ok} !== 6'b10_00_00) begin
        failed++; $display("FAIL wr_aw_wait[%0d]: got %b expected 100000", c, {awvalid, wvalid, sram_addr_ok, sram_data_ok});
      end
    end
    @(negedge clk); idle(); awready = 1'b0; wr_req(1, 32'h2100, 2'd2, 4'hF, 32'h0); #1;
    tests_run++;
    if ({awvalid, wvalid, sram_addr_ok, sram_data_ok} !== 6'b0) begin
      failed++; $display("FAIL wr_waitb: got %b expected 000000", {awvalid, wvalid, sram_addr_ok, sram_data_ok});
    end
    @(negedge clk); idle(); bvalid = 1'b1; bid = 4'd0; wr_req(1, 32'h2100, 2'd2, 4'hF, 32'h0); #1;
    tests_run++;
    if ({sram_data_ok, sram_addr_ok} !== 4'b01_00) begin
      failed++; $display("FAIL wr_bresp: got %b expected 0100", {sram_data_ok, sram_addr_ok});
    end
  endtask

  task automatic test_raw_block();
    @(negedge clk); idle(); wr_req(1, 32'h2000, 2'd2, 4'hF, 32'h0BAD_F00D);
    awready = 1'b0; wready = 1'b0; #1;
    tests_run++;
    if (sram_addr_ok !== 2'b10) begin
      failed++; $display("FAIL raw_wr_grant: got %b expected 10", sram_addr_ok);
    end
    @(negedge clk); idle(); rd_req(0, 32'h2000); #1;
    tests_run++;
    if ({awvalid, awid, wid, sram_addr_ok} !== {1'b1, 4'd1, 4'd1, 2'b00}) begin
      failed++; $display("FAIL raw_same_addr: got %h expected %h", {awvalid, awid, wid, sram_addr_ok}, {1'b1, 4'd1, 4'd1, 2'b00});
    end
    @(negedge clk); idle(); rd_req(1, 32'h2004); #1;
    tests_run++;
    if (sram_addr_ok !== 2'b00) begin
      failed++; $display("FAIL raw_same_ch: got %b expected 00", sram_addr_ok);
    end
    @(negedge clk); idle(); rd_req(0, 32'h3000); arready = 1'b1; #1;
    tests_run++;
    if (sram_addr_ok !== {1'b0, RAW_CHK}) begin
      failed++; $display("FAIL raw_other: got %b expected %b", sram_addr_ok, {1'b0, RAW_CHK});
    end
    @(negedge clk); idle(); awready = 1'b1; wready = 1'b1; #1;
    tests_run++;
    if ({arvalid, arvalid ? araddr : 32'h0} !== (RAW_CHK ? {1'b1, 32'h3000} : 33'h0)) begin
      failed++; $display("FAIL raw_ar: got %h expected %h", {arvalid, arvalid ? araddr : 32'h0},
                         (RAW_CHK ? {1'b1, 32'h3000} : 33'h0));
    end
    @(negedge clk); idle(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1; #1;
    tests_run++;
    if (sram_data_ok !== 2'b10) begin
      failed++; $display("FAIL raw_bresp: got %b expected 10", sram_data_ok);
    end
    @(negedge clk); idle();
    if (!RAW_CHK) rd_req(0, 32'h3000);
    @(negedge clk); idle();
    @(negedge clk); idle(); r_beat(4'd0, 32'hCAFE_F00D); #1;
    tests_run++;
    if ({sram_data_ok, sram_rdata[31:0]} !== {2'b01, 32'hCAFE_F00D}) begin
      failed++; $display("FAIL raw_rdata: got %h expected %h", {sram_data_ok, sram_rdata[31:0]}, {2'b01, 32'hCAFE_F00D});
    end
  endtask

  task automatic test_wr_after_rd();
    @(negedge clk); idle(); rd_req(0, 32'h4000); arready = 1'b1; #1;
    tests_run++;
    if (sram_addr_ok !== 2'b01) begin
      failed++; $display("FAIL war_rd_grant: got %b expected 01", sram_addr_ok);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); wr_req(0, 32'h5000, 2'd2, 4'hF, 32'h55AA_55AA);
      if (c == 2) r_beat(4'd0, 32'h0);
      #1;
      tests_run++;
      if ({sram_addr_ok, sram_data_ok} !== {2'b00, (c == 2) ? 2'b01 : 2'b00}) begin
        failed++; $display("FAIL war_blocked[%0d]: got %b expected %b", c, {sram_addr_ok, sram_data_ok},
                           {2'b00, (c == 2) ? 2'b01 : 2'b00});
      end
    end
    @(negedge clk); idle(); wr_req(0, 32'h5000, 2'd2, 4'hF, 32'h55AA_55AA);
    awready = 1'b1; wready = 1'b1; #1;
    tests_run++;
    if (sram_addr_ok !== 2'b01) begin
      failed++; $display("FAIL war_wr_grant: got %b expected 01", sram_addr_ok);
    end
    @(negedge clk); idle(); #1;
    tests_run++;
    if ({awvalid, wvalid, awid, awaddr, wdata} !== {2'b11, 4'd0, 32'h5000, 32'h55AA_55AA}) begin
      failed++; $display("FAIL war_aw_w: got %h expected %h", {awvalid, wvalid, awid, awaddr, wdata},
                         {2'b11, 4'd0, 32'h5000, 32'h55AA_55AA});
    end
    @(negedge clk); idle(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd0; #1;
    tests_run++;
    if ({awvalid, wvalid, sram_data_ok} !== 4'b00_01) begin
      failed++; $display("FAIL war_bresp: got %b expected 0001", {awvalid, wvalid, sram_data_ok});
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk); idle(); wr_req(1, 32'h6000, 2'd2, 4'hF, 32'h0); #1;
    tests_run++;
    if (sram_addr_ok !== 2'b10) begin
      failed++; $display("FAIL rst_wr_grant: got %b expected 10", sram_addr_ok);
    end
    @(negedge clk); idle(); #1;
    tests_run++;
    if ({awvalid, wvalid} !== 2'b11) begin
      failed++; $display("FAIL rst_pre: got %b expected 11", {awvalid, wvalid});
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({arvalid, awvalid, wvalid, sram_addr_ok, sram_data_ok} !== 7'b0) begin
      failed++; $display("FAIL rst_async: got %b expected 0", {arvalid, awvalid, wvalid, sram_addr_ok, sram_data_ok});
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); idle(); rd_req(0, 32'h7000); rd_req(1, 32'h7100); arready = 1'b1; #1;
    tests_run++;
    if ({awvalid, wvalid, sram_addr_ok} !== 4'b00_01) begin
      failed++; $display("FAIL rst_first_grant: got %b expected 0001", {awvalid, wvalid, sram_addr_ok});
    end
    @(negedge clk); idle(); #1;
    tests_run++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h7000}) begin
      failed++; $display("FAIL rst_arid: got %h expected %h", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h7000});
    end
  endtask

  initial begin
    resetn = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    idle();
    test_reset();
    test_rr_saturate();
    test_read_route();
    test_write_order();
    test_raw_block();
    test_wr_after_rd();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
